// File: rtl/prefetch_queue.sv
// prefetch_queue: circular byte queue fed from a byte-wide RAM port, with a
// big-endian window for the decoder. Ports: clk/reset, flush/flush_ip, ram_*, count, window, head_address, consume/consume_len. PREFETCH_STATS_EN adds starve_cycles/fetched_bytes.
module prefetch_queue #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int QUEUE_DEPTH   = 8,
  parameter int OPCODE_BYTES  = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic [ADDRESS_WIDTH-1:0]           flush_ip,
  output logic                               ram_req,
  output logic [ADDRESS_WIDTH-1:0]           ram_address,
  input  logic [7:0]                         ram_data,
  input  logic                               ram_busy,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   count,
  output logic [8*OPCODE_BYTES-1:0]          window,
  output logic [ADDRESS_WIDTH-1:0]           head_address,
  input  logic                               consume,
  input  logic [$clog2(OPCODE_BYTES+1)-1:0]  consume_len
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0]                        starve_cycles,
  output logic [31:0]                        fetched_bytes
`endif
);

  localparam int CW = $clog2(QUEUE_DEPTH+1);
  localparam int PW = (QUEUE_DEPTH > 1) ?
                      $clog2(QUEUE_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FULL
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [7:0]    mem [QUEUE_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] idx;
  logic          push;
  int            popped;
  logic [CW-1:0] count_n;

  // FETCH is only ever held while there is room, so the request is a
  // pure decode of state.
  assign ram_req = (state == FETCH);
  assign push    = ram_req && !ram_busy;

  // Pops see only the bytes already queued; a same-cycle push is excluded.
  always_comb begin
    popped = 0;
    if (consume) begin
      if (int'(consume_len) < int'(count))
        popped = int'(consume_len);
      else
        popped = int'(count);
    end
  end

  always_comb begin
    count_n = CW'(int'(count) + int'(push) - popped);
    state_n = state;
    if (state != IDLE)
      state_n = (int'(count_n) == QUEUE_DEPTH) ? FULL : FETCH;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      ram_address  <= '0;
      head_address <= '0;
    end else if (flush) begin
      state        <= FETCH;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      ram_address  <= flush_ip;
      head_address <= flush_ip;
    end else begin
      if (push) begin
        tail        <= PW'((int'(tail) + 1) % QUEUE_DEPTH);
        ram_address <= ram_address + ADDRESS_WIDTH'(1);
      end
      head         <= PW'((int'(head) + popped) % QUEUE_DEPTH);
      head_address <= head_address + ADDRESS_WIDTH'(popped);
      count        <= count_n;
      state        <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !reset)
      mem[tail] <= ram_data;
  end

  always_comb begin
    window = '0;
    idx    = '0;
    for (int i = 0; i < OPCODE_BYTES; i++) begin
      idx = PW'((int'(head) + i) % QUEUE_DEPTH);
      if (i < int'(count))
        window[8*(OPCODE_BYTES-i)-1 -: 8] = mem[idx];
    end
  end

`ifdef PREFETCH_STATS_EN
  // Flush does not clear these; a byte dropped by flush still counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cycles <= '0;
      fetched_bytes <= '0;
    end else begin
      if (state != IDLE && int'(count) < OPCODE_BYTES &&
          starve_cycles != '1)
        starve_cycles <= starve_cycles + 32'd1;
      if (push && fetched_bytes != '1)
        fetched_bytes <= fetched_bytes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prefetch_queue.sv
// tb_prefetch_queue: directed self-checking bench for prefetch_queue.
// RAM model returns the low address byte; checks sampled 1ns after each edge.
module tb_prefetch_queue;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [31:0] flush_ip;
  logic        ram_req;
  logic [31:0] ram_address;
  logic [7:0]  ram_data;
  logic        ram_busy;
  logic [3:0]  count;
  logic [31:0] window;
  logic [31:0] head_address;
  logic        consume;
  logic [2:0]  consume_len;
`ifdef PREFETCH_STATS_EN
  logic [31:0] starve_cycles;
  logic [31:0] fetched_bytes;
`endif

  int checks = 0;
  int errors = 0;

  assign ram_data = ram_address[7:0];

  prefetch_queue dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .flush_ip     (flush_ip),
    .ram_req      (ram_req),
    .ram_address  (ram_address),
    .ram_data     (ram_data),
    .ram_busy     (ram_busy),
    .count        (count),
    .window       (window),
    .head_address (head_address),
    .consume      (consume),
    .consume_len  (consume_len)
`ifdef PREFETCH_STATS_EN
    ,
    .starve_cycles(starve_cycles),
    .fetched_bytes(fetched_bytes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b1;
    flush       = 1'b0;
    flush_ip    = '0;
    ram_busy    = 1'b0;
    consume     = 1'b0;
    consume_len = '0;
    step();
    step();
    reset = 1'b0;
    chk("rst_req", 32'(ram_req), 32'd0);
    chk("rst_addr", ram_address, 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_window", window, 32'h0);
    chk("rst_head", head_address, 32'h0);
    step();
    chk("idle_req", 32'(ram_req), 32'd0);
    chk("idle_addr", ram_address, 32'h0);

    // 1: flush to 0x100, fetch four bytes
    flush    = 1'b1;
    flush_ip = 32'h100;
    step();
    flush = 1'b0;
    chk("t1_addr0", ram_address, 32'h100);
    chk("t1_req", 32'(ram_req), 32'd1);
    chk("t1_count0", 32'(count), 32'd0);
    step();
    step();
    chk("t1_addr2", ram_address, 32'h102);
    chk("t1_win2", window, 32'h00010000);
    step();
    step();
    chk("t1_count4", 32'(count), 32'd4);
    chk("t1_win4", window, 32'h00010203);
    chk("t1_head", head_address, 32'h100);

    // 2: fill to FULL, then pop 3
    repeat (4) step();
    chk("t2_count8", 32'(count), 32'd8);
    chk("t2_req_full", 32'(ram_req), 32'd0);
    chk("t2_addr", ram_address, 32'h108);
    step();
    chk("t2_hold_count", 32'(count), 32'd8);
    chk("t2_hold_addr", ram_address, 32'h108);
    consume     = 1'b1;
    consume_len = 3'd3;
    step();
    consume = 1'b0;
    chk("t2_count5", 32'(count), 32'd5);
    chk("t2_head", head_address, 32'h103);
    chk("t2_win", window, 32'h03040506);
    chk("t2_req", 32'(ram_req), 32'd1);

    // 4b: push and pop together at count 5
    consume     = 1'b1;
    consume_len = 3'd2;
    step();
    consume = 1'b0;
    chk("pp_count", 32'(count), 32'd4);
    chk("pp_head", head_address, 32'h105);
    chk("pp_addr", ram_address, 32'h109);
    chk("pp_win", window, 32'h05060708);

    // 3: busy every other cycle
    ram_busy = 1'b1;
    step();
    chk("bz_c0", 32'(count), 32'd4);
    chk("bz_a0", ram_address, 32'h109);
    ram_busy = 1'b0;
    step();
    chk("bz_c1", 32'(count), 32'd5);
    chk("bz_a1", ram_address, 32'h10a);
    ram_busy = 1'b1;
    step();
    chk("bz_c2", 32'(count), 32'd5);
    ram_busy = 1'b0;
    step();
    chk("bz_c3", 32'(count), 32'd6);
    chk("bz_a3", ram_address, 32'h10b);
    ram_busy    = 1'b1;
    consume     = 1'b1;
    consume_len = 3'd4;
    step();
    chk("bz_count", 32'(count), 32'd2);
    chk("bz_head", head_address, 32'h109);
    chk("bz_win", window, 32'h090a0000);

    // 4a: over-long pop clamps to count
    step();
    consume = 1'b0;
    chk("clamp_count", 32'(count), 32'd0);
    chk("clamp_head", head_address, 32'h10b);
    chk("clamp_win", window, 32'h0);

    // consume_len 0 is a no-op while a byte arrives
    ram_busy    = 1'b0;
    consume     = 1'b1;
    consume_len = 3'd0;
    step();
    consume = 1'b0;
    chk("nop_count", 32'(count), 32'd1);
    chk("nop_head", head_address, 32'h10b);
    chk("nop_win", window, 32'h0b000000);

    // 5: flush during an accept, then address wrap
    flush    = 1'b1;
    flush_ip = 32'hffff_fffe;
    step();
    flush = 1'b0;
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_addr", ram_address, 32'hffff_fffe);
    chk("fl_head", head_address, 32'hffff_fffe);
    chk("fl_win", window, 32'h0);
    step();
    chk("wr_addr1", ram_address, 32'hffff_ffff);
    chk("wr_win1", window, 32'hfe000000);
    step();
    chk("wr_addr2", ram_address, 32'h0);
    step();
    chk("wr_addr3", ram_address, 32'h1);
    chk("wr_win3", window, 32'hfeff0000);
    ram_busy    = 1'b1;
    consume     = 1'b1;
    consume_len = 3'd3;
    step();
    consume = 1'b0;
    chk("wr_head", head_address, 32'h1);
    chk("wr_count", 32'(count), 32'd0);

    // 6: fill to FULL, reset with consume held
    ram_busy = 1'b0;
    repeat (8) step();
    chk("f6_count", 32'(count), 32'd8);
    chk("f6_req", 32'(ram_req), 32'd0);
    chk("f6_win", window, 32'h01020304);
`ifdef PREFETCH_STATS_EN
    chk("st_fetched", fetched_bytes, 32'd24);
`endif
    reset       = 1'b1;
    consume     = 1'b1;
    consume_len = 3'd2;
    step();
    reset   = 1'b0;
    consume = 1'b0;
    chk("r6_req", 32'(ram_req), 32'd0);
    chk("r6_addr", ram_address, 32'h0);
    chk("r6_count", 32'(count), 32'd0);
    chk("r6_win", window, 32'h0);
    chk("r6_head", head_address, 32'h0);
`ifdef PREFETCH_STATS_EN
    chk("r6_starve", starve_cycles, 32'd0);
    chk("r6_fetched", fetched_bytes, 32'd0);
`endif
    step();
    step();
    chk("r6_idle_req", 32'(ram_req), 32'd0);
    chk("r6_idle_addr", ram_address, 32'h0);
    chk("r6_idle_count", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prefetch_queue.md
Name: prefetch_queue

Overview:
Parametrised successor to the fixed 4-byte opcode loader. It continuously prefetches instruction bytes from the byte-wide RAM port into a circular byte queue of QUEUE_DEPTH entries. It presents the next OPCODE_BYTES bytes as a big-endian window to the decoder. The decoder pops a variable number of bytes per cycle, and a flush redirects fetch to a new IP, for jumps and calls. It sits between the RAM arbiter and the instruction decoder.

Parameters:
ADDRESS_WIDTH, 32, width of fetch and head addresses; wraps modulo 2^ADDRESS_WIDTH.
QUEUE_DEPTH, 8, byte capacity of the queue; power of 2, at least OPCODE_BYTES.
OPCODE_BYTES, 4, bytes in the output window and maximum pop per cycle; range 1..QUEUE_DEPTH.

Ports:
clk  in  1  clock.
reset  in  1  reset, synchronous, active-high.
flush  in  1  discard queue and restart fetching at flush_ip.
flush_ip  in  ADDRESS_WIDTH  new fetch address, sampled when flush=1.
ram_req  out  1  read request for byte at ram_address.
ram_address  out  ADDRESS_WIDTH  registered fetch address.
ram_data  in  8  read data, valid when ram_req=1 and ram_busy=0.
ram_busy  in  1  RAM not ready; the byte is not accepted this cycle.
count  out  clog2(QUEUE_DEPTH+1)  bytes currently queued.
window  out  8*OPCODE_BYTES  head byte in bits [8*OPCODE_BYTES-1 -: 8], next byte below; unfilled bytes read 0.
head_address  out  ADDRESS_WIDTH  address of the byte in the top window slot.
consume  in  1  pop request.
consume_len  in  clog2(OPCODE_BYTES+1)  bytes to pop when consume=1.

Behaviour:
- Reset values: ram_req=0, ram_address=0, count=0, window=0, head_address=0, state=IDLE, queue pointers 0. Reset has priority over every other input, including mid-fetch.
- States:
  - IDLE: no fetch, ram_req=0. flush moves to FETCH.
  - FETCH: ram_req=1 whenever count<QUEUE_DEPTH.
  - FULL: count==QUEUE_DEPTH, ram_req=0. Returns to FETCH on the edge where count drops below QUEUE_DEPTH.
- All outputs are registered or decoded from registered state. ram_req is never derived combinationally from consume.
- Byte accept: ram_req=1 and ram_busy=0 at a rising edge.
  - ram_data is written at the tail.
  - tail advances mod QUEUE_DEPTH.
  - ram_address increments, wrapping all-ones to 0.
  - The byte is visible in count and window from the next cycle, giving 1-cycle latency.
- Pop: consume=1 at an edge removes min(consume_len, count) bytes from the head and advances head_address by the same amount, with wrap. consume_len=0 is a no-op. A pop larger than count is clamped to count; it is never an error.
- Push and pop in the same cycle:
  - Both take effect.
  - count_next = count + push - popped.
  - A byte pushed this cycle is not poppable this cycle.
- flush=1 at an edge, with priority over push and pop:
  - count=0, pointers cleared.
  - ram_address=flush_ip, head_address=flush_ip.
  - state=FETCH.
  - Any byte accepted in that same cycle is discarded.
- flush during IDLE, FETCH or FULL behaves identically.
- window slot i, where i=0 is the head, shows queue[(head+i) mod QUEUE_DEPTH] if i<count, else 8'h00.
- After reset the block stays in IDLE until the first flush.

Optional Feature:
PREFETCH_STATS_EN
- Defined: adds outputs starve_cycles (32-bit) and fetched_bytes (32-bit).
  - starve_cycles increments in every cycle where state!=IDLE and count<OPCODE_BYTES.
  - fetched_bytes increments on each byte accept, including bytes discarded by a same-cycle flush.
  - Both saturate at all-ones and are cleared only by reset, not by flush.
- Undefined: neither port nor their logic exists; all other behaviour is identical.

Test Plan:
1. Reset, then flush with flush_ip=0x100, RAM returning addr[7:0] with ram_busy=0 -> ram_address 0x100,0x101,… on successive cycles. After 4 accepts: window=0x00010203, count=4, head_address=0x100.
2. Fill with no consume -> count reaches 8, ram_req=0 (FULL), ram_address=0x108. consume_len=3 -> count=5, head_address=0x103, window=0x03040506, ram_req=1 next cycle.
3. ram_busy toggled high every other cycle -> exactly one byte per non-busy cycle, no duplicates or gaps, window byte order preserved.
4. count=2, consume=1 with consume_len=4 -> count=0, head_address advanced by 2, window=0. Simultaneous push+pop at count=5 with consume_len=2 -> count=4.
5. Mid-fetch flush with flush_ip=0xFFFFFFFE in the same cycle as an accept -> count=0, accepted byte dropped. Subsequent addresses are 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
6. Reset asserted while FULL with consume=1 -> all outputs return to reset values and the block stays in IDLE. With PREFETCH_STATS_EN, starve_cycles=0 and fetched_bytes=0.
